apb_io_responder: RTL and testbench
===================================

Name: apb_io_responder

Overview:
APB-style responder serving the input-peripheral window: board switches and push-buttons behind a memory-mapped register file. Synchronizes and debounces raw pad inputs, latches button press edges with write-1-to-clear semantics and raises a maskable interrupt. Inserts a programmable number of wait states per access. Sits on the same paddr/pwrite/penable/psel/pstrb/pready/prdata bus the load-store unit drives into data memory.

Parameters:
SW_W, 32, switch input width (max 32)
BTN_W, 4, button input width (max 8)
DB_W, 16, debounce limit register width
DB_CYCLES, 16'd50000, reset value of debounce tick period in clk cycles
WAIT_STATES, 1, wait cycles inserted before pready_o in ACCESS (0..7)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
paddr_i  in  12  byte address within window; bits [1:0] ignored
psel_i  in  1  select
penable_i  in  1  access phase
pwrite_i  in  1  1 write, 0 read
pwdata_i  in  32  write data
pstrb_i  in  4  byte write strobes
pready_o  out  1  transfer complete
prdata_o  out  32  read data, valid only when pready_o=1
pslverr_o  out  1  error, valid only when pready_o=1
i_io_sw  in  SW_W  raw switches, asynchronous
i_io_btn  in  BTN_W  raw buttons, asynchronous, active-high
o_irq  out  1  registered interrupt

Behaviour:
- Reset (asynchronous, rst_ni=0): pready_o=0, prdata_o=0, pslverr_o=0, o_irq=0, all sync/debounce/edge/IRQ_EN state 0, DB_LIMIT=DB_CYCLES, tick counter 0, FSM IDLE. Reset mid-transfer aborts it; no register is written.
- Register map (offset = paddr_i[11:2]<<2):
  0x000 SW_STATUS RO: debounced switches, zero-extended.
  0x004 BTN_STATUS RO: debounced buttons, zero-extended.
  0x008 BTN_EDGE RW1C: [BTN_W-1:0] press latches; write with pstrb_i[0]=1 clears bits where pwdata_i=1.
  0x00C IRQ_EN RW: [BTN_W-1:0], byte 0 via pstrb_i[0].
  0x010 DB_LIMIT RW: [DB_W-1:0], per-byte strobes; any write resets tick counter to 0.
  Other offset: read returns 32'hCAFECAFE, pslverr_o=1; write ignored, pslverr_o=1. Writes to RO registers: ignored, pslverr_o=1.
- FSM: IDLE -> SETUP when psel_i=1 & penable_i=0. SETUP -> ACCESS next cycle; wait counter cleared. ACCESS: counter increments each cycle; pready_o=1 in the cycle counter==WAIT_STATES; WAIT_STATES=0 gives pready_o in the first ACCESS cycle. After the pready cycle -> SETUP if psel_i=1 & penable_i=0, else IDLE. psel_i dropping during ACCESS -> IDLE, no commit. penable_i=1 seen in IDLE is ignored.
- pready_o, prdata_o, pslverr_o are combinational from registered state; prdata_o=0 and pslverr_o=0 whenever pready_o=0.
- Writes commit at the clock edge ending the pready_o=1 cycle. Reads sample the register value in that cycle.
- Input path: 2-flop synchronizer per bit. Tick counter counts 0..DB_LIMIT-1 and pulses tick at DB_LIMIT-1; DB_LIMIT=0 behaves as 1 (tick every cycle).
- Debounce: on tick, sample <= sync; if sync==previous sample, debounced <= sync. A change stable for two consecutive ticks is accepted; glitches shorter than one tick period are rejected.
- Edge: debounced button 0->1 sets BTN_EDGE bit. Same-cycle set and W1C clear: set wins.
- o_irq <= |(BTN_EDGE & IRQ_EN), one-cycle register delay.

Test Plan:
- Reset, WAIT_STATES=1: read 0x010 -> pready_o high 2nd ACCESS cycle, prdata_o=50000, pslverr_o=0; prdata_o=0 in the cycle before.
- DB_LIMIT=4, i_io_sw=32'h0000A5A5 held -> SW_STATUS reads 0xA5A5 within 2+8 cycles; a 2-cycle pulse on sw[0] does not change SW_STATUS.
- DB_LIMIT=4, IRQ_EN=4'b0010, press btn[1] 20 cycles -> BTN_EDGE=0x2, o_irq=1; write 0x008 pwdata=0x2 pstrb=1 -> BTN_EDGE=0, o_irq=0 next cycle.
- New btn[1] edge in the same cycle as its W1C commit -> BTN_EDGE[1] stays 1.
- Read 0x01C -> prdata_o=32'hCAFECAFE, pslverr_o=1; write 0x000 -> pslverr_o=1, SW_STATUS unchanged.
- Write DB_LIMIT=0x1234 pstrb=4'b0001 -> reads 0xC334; rst_ni low during ACCESS of a write -> no commit, pready_o=0, DB_LIMIT=50000.

Source files
------------

// File: rtl/apb_io_responder.sv
// APB responder for the input-peripheral window: switches and buttons
// behind a small register file with debounce, W1C press latches and IRQ.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   paddr_i .. pstrb_i    APB request (addr, select, enable, write, data, strobes)
//   pready_o, prdata_o,   APB response; data/error are zero unless pready_o=1
//   pslverr_o
//   i_io_sw, i_io_btn     raw asynchronous pad inputs
//   o_irq                 registered interrupt: any enabled button press latch
module apb_io_responder #(
    parameter int unsigned     SW_W        = 32,
    parameter int unsigned     BTN_W       = 4,
    parameter int unsigned     DB_W        = 16,
    parameter logic [DB_W-1:0] DB_CYCLES   = 16'd50000,
    parameter int unsigned     WAIT_STATES = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [11:0]      paddr_i,
    input  logic             psel_i,
    input  logic             penable_i,
    input  logic             pwrite_i,
    input  logic [31:0]      pwdata_i,
    input  logic [3:0]       pstrb_i,
    output logic             pready_o,
    output logic [31:0]      prdata_o,
    output logic             pslverr_o,
    input  logic [SW_W-1:0]  i_io_sw,
    input  logic [BTN_W-1:0] i_io_btn,
    output logic             o_irq
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_e      state_q;
    logic [2:0]  wcnt_q;
    logic [9:0]  addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;

    logic [SW_W-1:0]  sw_meta_q, sw_sync_q, sw_samp_q, sw_deb_q, sw_deb_d;
    logic [BTN_W-1:0] btn_meta_q, btn_sync_q, btn_samp_q, btn_deb_q, btn_deb_d;
    logic [BTN_W-1:0] edge_q, edge_d, irq_en_q, irq_en_d, clr;
    logic [DB_W-1:0]  db_limit_q, db_limit_d, tick_cnt_q, tick_cnt_d, lim_m1;
    logic             irq_q, tick, commit, err;
    logic [31:0]      rdata;

    logic unused_ok;
    assign unused_ok = ^{paddr_i[1:0], wdata_q, strb_q[3:1]};

    assign pready_o  = (state_q == ACCESS) && (wcnt_q == WS);
    assign prdata_o  = pready_o ? rdata : 32'h0;
    assign pslverr_o = pready_o & err;
    assign o_irq     = irq_q;

    // Master releasing psel in the completion cycle abandons the transfer.
    assign commit = pready_o && psel_i && write_q;

    // Bus FSM; the request is captured when SETUP is entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        state_q <= SETUP;
                        addr_q  <= paddr_i[11:2];
                        write_q <= pwrite_i;
                        wdata_q <= pwdata_i;
                        strb_q  <= pstrb_i;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    wcnt_q  <= '0;
                end
                ACCESS: begin
                    if (!psel_i) begin
                        state_q <= IDLE;
                    end else if (wcnt_q == WS) begin
                        if (!penable_i) begin
                            state_q <= SETUP;
                            addr_q  <= paddr_i[11:2];
                            write_q <= pwrite_i;
                            wdata_q <= pwdata_i;
                            strb_q  <= pstrb_i;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (addr_q)
            10'd0:   rdata[SW_W-1:0]  = sw_deb_q;
            10'd1:   rdata[BTN_W-1:0] = btn_deb_q;
            10'd2:   rdata[BTN_W-1:0] = edge_q;
            10'd3:   rdata[BTN_W-1:0] = irq_en_q;
            10'd4:   rdata[DB_W-1:0]  = db_limit_q;
            default: rdata = 32'hCAFECAFE;
        endcase
        err = (addr_q > 10'd4) || (write_q && addr_q < 10'd2);
    end

    // A limit of 0 ticks every cycle, same as 1.
    assign lim_m1 = (db_limit_q == '0) ? '0 : db_limit_q - DB_W'(1);
    assign tick   = tick_cnt_q >= lim_m1;

    always_comb begin
        db_limit_d = db_limit_q;
        irq_en_d   = irq_en_q;
        clr        = '0;
        tick_cnt_d = tick ? '0 : tick_cnt_q + DB_W'(1);
        if (commit && addr_q == 10'd4) begin
            tick_cnt_d = '0;
            for (int i = 0; i < int'(DB_W); i++) begin
                if (strb_q[i/8]) db_limit_d[i] = wdata_q[i];
            end
        end
        if (commit && addr_q == 10'd3 && strb_q[0]) begin
            irq_en_d = wdata_q[BTN_W-1:0];
        end
        if (commit && addr_q == 10'd2 && strb_q[0]) begin
            clr = wdata_q[BTN_W-1:0];
        end
        // Accept a bit once two consecutive tick samples agree.
        sw_deb_d  = sw_deb_q;
        btn_deb_d = btn_deb_q;
        if (tick) begin
            sw_deb_d  = (~(sw_sync_q ^ sw_samp_q) & sw_sync_q)
                      | ((sw_sync_q ^ sw_samp_q) & sw_deb_q);
            btn_deb_d = (~(btn_sync_q ^ btn_samp_q) & btn_sync_q)
                      | ((btn_sync_q ^ btn_samp_q) & btn_deb_q);
        end
        // A new press in the same cycle as its clear survives.
        edge_d = (edge_q & ~clr) | (btn_deb_d & ~btn_deb_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            sw_samp_q  <= '0;
            sw_deb_q   <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            btn_samp_q <= '0;
            btn_deb_q  <= '0;
            edge_q     <= '0;
            irq_en_q   <= '0;
            db_limit_q <= DB_CYCLES;
            tick_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sw_meta_q  <= i_io_sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= i_io_btn;
            btn_sync_q <= btn_meta_q;
            if (tick) begin
                sw_samp_q  <= sw_sync_q;
                btn_samp_q <= btn_sync_q;
            end
            sw_deb_q   <= sw_deb_d;
            btn_deb_q  <= btn_deb_d;
            edge_q     <= edge_d;
            irq_en_q   <= irq_en_d;
            db_limit_q <= db_limit_d;
            tick_cnt_q <= tick_cnt_d;
            irq_q      <= |(edge_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_apb_io_responder.sv
// Directed plus randomized bench for apb_io_responder.
// Expected values come from a register-level model of the window.
module tb_apb_io_responder;

    localparam int unsigned WS  = 1;
    localparam logic [15:0] DBC = 16'd50000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_db;
    logic [3:0]  m_en, m_edge;
    logic [31:0] m_sw;

    logic [31:0] rd;
    logic        er;
    int          lat;

    always #5 clk = ~clk;

    apb_io_responder #(
        .SW_W(32), .BTN_W(4), .DB_W(16),
        .DB_CYCLES(DBC), .WAIT_STATES(WS)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
        .i_io_sw(sw), .i_io_btn(btn), .o_irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [11:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rdo, output logic ero,
                        output int lato);
        logic got;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a;
        pwrite = w; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        got = 1'b0;
        lato = 0;
        rdo = '0;
        ero = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lato++;
            if (pready) begin
                got = 1'b1;
                rdo = prdata;
                ero = pslverr;
            end else begin
                chk("prdata_not_ready", prdata, 32'h0);
            end
        end
        chk("xfer_done", {31'h0, got}, 32'h1);
        chk("latency", lato, WS + 2);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_read(input logic [9:0] idx);
        case (idx)
            10'd0:   return m_sw;
            10'd1:   return 32'h0;
            10'd2:   return {28'h0, m_edge};
            10'd3:   return {28'h0, m_en};
            10'd4:   return {16'h0, m_db};
            default: return 32'hCAFECAFE;
        endcase
    endfunction

    initial begin
        logic [11:0] a;
        logic [9:0]  idx;
        logic        w;
        logic [31:0] wd;
        logic [3:0]  st;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; sw = '0; btn = '0;
        m_db = DBC; m_en = '0; m_edge = '0; m_sw = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", {31'h0, pready}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;

        xfer(12'h010, 1'b0, '0, '0, rd, er, lat);
        chk("db_reset_val", rd, 32'd50000);
        chk("db_reset_err", {31'h0, er}, 32'h0);

        xfer(12'h010, 1'b1, 32'd4, 4'hF, rd, er, lat);
        m_db = 16'd4;
        sw = 32'h0000A5A5; m_sw = sw;
        wait_cyc(30);
        xfer(12'h000, 1'b0, '0, '0, rd, er, lat);
        chk("sw_status", rd, m_read(10'd0));
        sw = 32'h0000A5A4;
        wait_cyc(2);
        sw = 32'h0000A5A5;
        wait_cyc(30);
        xfer(12'h000, 1'b0, '0, '0, rd, er, lat);
        chk("sw_glitch", rd, m_read(10'd0));

        xfer(12'h00C, 1'b1, 32'h2, 4'h1, rd, er, lat);
        m_en = 4'b0010;
        btn = 4'b0010;
        wait_cyc(20);
        xfer(12'h004, 1'b0, '0, '0, rd, er, lat);
        chk("btn_status", rd, 32'h2);
        btn = 4'b0000;
        m_edge = 4'b0010;
        wait_cyc(30);
        xfer(12'h008, 1'b0, '0, '0, rd, er, lat);
        chk("btn_edge", rd, m_read(10'd2));
        @(negedge clk);
        chk("irq_set", {31'h0, irq}, {31'h0, |(m_edge & m_en)});
        xfer(12'h008, 1'b1, 32'h2, 4'h1, rd, er, lat);
        m_edge = 4'b0000;
        @(posedge clk); @(negedge clk);
        chk("irq_clr", {31'h0, irq}, {31'h0, |(m_edge & m_en)});
        xfer(12'h008, 1'b0, '0, '0, rd, er, lat);
        chk("btn_edge_clr", rd, m_read(10'd2));

        // With a tick every cycle, a press driven after posedge k is
        // debounced and latched at posedge k+4; aim that at the W1C commit.
        xfer(12'h010, 1'b1, 32'd1, 4'hF, rd, er, lat);
        m_db = 16'd1;
        btn = 4'b0010;
        wait_cyc(10);
        btn = 4'b0000;
        wait_cyc(10);
        fork
            begin
                @(posedge clk);
                xfer(12'h008, 1'b1, 32'h2, 4'h1, rd, er, lat);
            end
            begin
                @(posedge clk);
                repeat (WS) @(posedge clk);
                #1 btn = 4'b0010;
            end
        join
        xfer(12'h008, 1'b0, '0, '0, rd, er, lat);
        chk("set_wins", rd, 32'h2);
        m_edge = 4'b0010;
        btn = 4'b0000;
        wait_cyc(10);

        xfer(12'h01C, 1'b0, '0, '0, rd, er, lat);
        chk("bad_rd_data", rd, 32'hCAFECAFE);
        chk("bad_rd_err", {31'h0, er}, 32'h1);
        xfer(12'h000, 1'b1, 32'h0, 4'hF, rd, er, lat);
        chk("ro_wr_err", {31'h0, er}, 32'h1);
        xfer(12'h000, 1'b0, '0, '0, rd, er, lat);
        chk("ro_wr_kept", rd, m_read(10'd0));

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: idx = 10'd0;
                1: idx = 10'd1;
                2: idx = 10'd2;
                3: idx = 10'd3;
                4: idx = 10'd4;
                default: idx = 10'($urandom_range(5, 1023));
            endcase
            a  = {idx, 2'($urandom)};
            w  = 1'($urandom);
            wd = $urandom;
            st = 4'($urandom);
            xfer(a, w, wd, st, rd, er, lat);
            chk("rnd_err", {31'h0, er},
                {31'h0, (idx > 10'd4) || (w && idx < 10'd2)});
            if (!w) chk("rnd_rdata", rd, m_read(idx));
            if (w && idx == 10'd2 && st[0]) m_edge = m_edge & ~wd[3:0];
            if (w && idx == 10'd3 && st[0]) m_en = wd[3:0];
            if (w && idx == 10'd4) begin
                if (st[0]) m_db[7:0]  = wd[7:0];
                if (st[1]) m_db[15:8] = wd[15:8];
            end
            @(posedge clk); @(negedge clk);
            chk("rnd_irq", {31'h0, irq}, {31'h0, |(m_edge & m_en)});
        end

        @(negedge clk);
        rst_n = 1'b0;
        wait_cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        m_db = DBC; m_en = '0; m_edge = '0;
        xfer(12'h010, 1'b1, 32'h1234, 4'b0001, rd, er, lat);
        m_db[7:0] = 8'h34;
        xfer(12'h010, 1'b0, '0, '0, rd, er, lat);
        chk("db_byte0", rd, m_read(10'd4));

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 12'h010;
        pwrite = 1'b1; pwdata = 32'h1; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_pready", {31'h0, pready}, 32'h0);
        @(negedge clk);
        chk("abort_pready2", {31'h0, pready}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        wait_cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        m_db = DBC;
        xfer(12'h010, 1'b0, '0, '0, rd, er, lat);
        chk("abort_db", rd, m_read(10'd4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
